// File: rtl/pisca_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pisca_pkg                                                        |
// | Shared mode encoding and index-width helper for pisca_multi.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pisca_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    BLINK   = 2'd2,
    ONESHOT = 2'd3
  } mode_e;

  // Channel index width; a single channel still gets a 1-bit index port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pisca_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pisca_ch                                                         |
// | One LED channel: OFF / ON / BLINK / ONESHOT with period counter. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pisca_ch
  import pisca_pkg::*;
#(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_wr,
  input  mode_e            i_mode,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_led,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] c_default_period = CNT_W'(DEFAULT_PERIOD);

  mode_e            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_done;
  logic             w_at_end;

  assign w_at_end = (r_cnt == r_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= OFF;
      r_period <= c_default_period;
      r_cnt    <= '0;
      r_led    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A write wins over a terminal count landing on the same edge.
      if (i_wr) begin
        r_mode   <= i_mode;
        r_period <= i_period;
        r_cnt    <= '0;
        r_led    <= (i_mode == ON) || (i_mode == ONESHOT);
      end else begin
        case (r_mode)
          OFF: begin
            r_led <= 1'b0;
            r_cnt <= '0;
          end
          ON: begin
            r_led <= 1'b1;
            r_cnt <= '0;
          end
          BLINK: begin
            if (i_tick) begin
              if (w_at_end) begin
                r_led <= ~r_led;
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ONESHOT: begin
            if (i_tick) begin
              if (w_at_end) begin
                r_led  <= 1'b0;
                r_cnt  <= '0;
                r_mode <= OFF;
                r_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          default: r_mode <= OFF;
        endcase
      end
    end
  end

  assign o_led  = r_led;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/pisca_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pisca_multi                                                      |
// | N_CH independent LED blinkers with write decode and optional     |
// | shared tick prescaler (enabled by macro PISCA_PRESCALE_EN).      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pisca_multi
  import pisca_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 25_000_000,
  parameter int PRESCALE       = 50
) (
  input  logic                        CLOCK_50,
  input  logic                        KEY,
  input  logic                        cfg_we,
  input  logic [ch_width(N_CH)-1:0]   cfg_ch,
  input  logic [MODE_W-1:0]           cfg_mode,
  input  logic [CNT_W-1:0]            cfg_period,
  output logic [N_CH-1:0]             LEDG,
  output logic [N_CH-1:0]             done
);

  localparam int c_ch_w = ch_width(N_CH);

  logic  w_tick;
  mode_e w_mode;

  assign w_mode = mode_e'(cfg_mode);

`ifdef PISCA_PRESCALE_EN
  localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [c_pre_w-1:0] r_pre;

  assign w_tick = (r_pre == c_pre_w'(PRESCALE - 1));

  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + c_pre_w'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Indices at or above N_CH match no channel, so such writes are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic w_hit;

    assign w_hit = cfg_we && (cfg_ch == c_ch_w'(g));

    pisca_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk      (CLOCK_50),
      .rst      (KEY),
      .i_tick   (w_tick),
      .i_wr     (w_hit),
      .i_mode   (w_mode),
      .i_period (cfg_period),
      .o_led    (LEDG[g]),
      .o_done   (done[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pisca_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pisca_multi                                                   |
// | Scoreboard bench for pisca_multi (N_CH=4, CNT_W=26).             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pisca_multi;
  import pisca_pkg::*;

  logic        CLOCK_50;
  logic        KEY;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [25:0] cfg_period;
  logic [3:0]  LEDG;
  logic [3:0]  done;

  pisca_multi #(
    .N_CH           (4),
    .CNT_W          (26),
    .DEFAULT_PERIOD (25_000_000),
    .PRESCALE       (50)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .KEY        (KEY),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .LEDG       (LEDG),
    .done       (done)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic [3:0] dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] led, input logic [3:0] dn);
    sb.push_back('{tag: tag, led: led, dn: dn});
  endtask

  // Advance one edge, then compare the oldest expectation against the outputs.
  task automatic cyc();
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_led"}, {28'd0, LEDG}, {28'd0, e.led});
      check({e.tag, "_done"}, {28'd0, done}, {28'd0, e.dn});
    end
  endtask

  task automatic wr(input logic [1:0] ch, input mode_e m, input logic [25:0] p);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = m;
    cfg_period = p;
  endtask

  task automatic nowr();
    cfg_we = 1'b0;
  endtask

  // Reset pulse entirely between edges; outputs must clear without a clock.
  task automatic rst_pulse(input string tag);
    nowr();
    KEY = 1'b1;
    #1;
    check({tag, "_async_led"}, {28'd0, LEDG}, 32'd0);
    check({tag, "_async_done"}, {28'd0, done}, 32'd0);
    KEY = 1'b0;
  endtask

  initial begin
    logic [3:0] el;
    logic [3:0] ed;

    KEY        = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    #12;
    check("por_led", {28'd0, LEDG}, 32'd0);
    check("por_done", {28'd0, done}, 32'd0);
    KEY = 1'b0;

    // Idle after reset: nothing lights without a write.
    for (int k = 0; k < 5; k++) begin
      expect_cycle("idle", 4'b0000, 4'b0000);
      cyc();
    end

    // ch0 ON, then asynchronous reset clears it mid-cycle.
    for (int k = 0; k < 3; k++) begin
      if (k == 0) wr(2'd0, ON, 26'd0); else nowr();
      expect_cycle("on0", 4'b0001, 4'b0000);
      cyc();
    end
    rst_pulse("on0");

    // ch0 BLINK P=4: half-periods of 5 cycles.
    for (int k = 0; k < 30; k++) begin
      if (k == 0) wr(2'd0, BLINK, 26'd4); else nowr();
      el = 4'b0000;
      el[0] = ((k / 5) % 2) == 1;
      expect_cycle("blink0", el, 4'b0000);
      cyc();
    end
    rst_pulse("blink0");

    // ch2 ONESHOT P=9: 10 cycles high, single done pulse, then OFF.
    for (int k = 0; k < 16; k++) begin
      if (k == 0) wr(2'd2, ONESHOT, 26'd9); else nowr();
      el = 4'b0000;
      ed = 4'b0000;
      el[2] = (k < 10);
      ed[2] = (k == 10);
      expect_cycle("shot2", el, ed);
      cyc();
    end
    rst_pulse("shot2");

    // ch1 BLINK P=3, rewritten P=7 on its terminal edge: next toggle 8 later.
    for (int k = 0; k < 23; k++) begin
      if (k == 0)      wr(2'd1, BLINK, 26'd3);
      else if (k == 4) wr(2'd1, BLINK, 26'd7);
      else             nowr();
      el = 4'b0000;
      el[1] = (k >= 12 && k < 20);
      expect_cycle("rewr1", el, 4'b0000);
      cyc();
    end
    rst_pulse("rewr1");

    // ch2 ONESHOT P=2 rewritten on its terminal edge: no done, restart.
    for (int k = 0; k < 9; k++) begin
      if (k == 0 || k == 3) wr(2'd2, ONESHOT, 26'd2); else nowr();
      el = 4'b0000;
      ed = 4'b0000;
      el[2] = (k < 6);
      ed[2] = (k == 6);
      expect_cycle("coll2", el, ed);
      cyc();
    end
    rst_pulse("coll2");

    // ch0 BLINK P=0 toggles every tick; ch3 ON then OFF leaves ch0 alone.
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      wr(2'd0, BLINK, 26'd0);
      else if (k == 3) wr(2'd3, ON, 26'd0);
      else if (k == 6) wr(2'd3, OFF, 26'd5);
      else             nowr();
      el = 4'b0000;
      el[0] = (k % 2) == 1;
      el[3] = (k >= 3 && k < 6);
      expect_cycle("indep", el, 4'b0000);
      cyc();
    end
    rst_pulse("indep");

    // ch1 ONESHOT P=0: high for exactly one tick.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) wr(2'd1, ONESHOT, 26'd0); else nowr();
      el = 4'b0000;
      ed = 4'b0000;
      el[1] = (k == 0);
      ed[1] = (k == 1);
      expect_cycle("shot1p0", el, ed);
      cyc();
    end
    rst_pulse("shot1p0");

    // ch3 ONESHOT P=20 aborted by KEY at cycle 10: no done ever.
    for (int k = 0; k < 10; k++) begin
      if (k == 0) wr(2'd3, ONESHOT, 26'd20); else nowr();
      expect_cycle("abort3", 4'b1000, 4'b0000);
      cyc();
    end
    KEY = 1'b1;
    #1;
    check("abort3_async_led", {28'd0, LEDG}, 32'd0);
    check("abort3_async_done", {28'd0, done}, 32'd0);
    expect_cycle("abort3_hold", 4'b0000, 4'b0000);
    cyc();
    KEY = 1'b0;
    for (int k = 0; k < 25; k++) begin
      expect_cycle("abort3_after", 4'b0000, 4'b0000);
      cyc();
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
